// File: rtl/crypto_pkg.sv
// Shared types for the image cipher datapath: pixel width, RGB triplet and decrypt FSM states.
package crypto_pkg;

    localparam int PIX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    function automatic rgb_t rgb_xor(input rgb_t a, input rgb_t k);
        return rgb_t'(a ^ k);
    endfunction

endpackage

// File: rtl/decrypt_stream_if.sv
// Cipher-in / plaintext-out valid-ready pixel streams of the decrypt engine.
// slave is the engine side, master is the source/sink side.
interface decrypt_stream_if;
    import crypto_pkg::*;

    logic             c_valid;
    logic             c_ready;
    logic [PIX_W-1:0] c_r;
    logic [PIX_W-1:0] c_g;
    logic [PIX_W-1:0] c_b;
    logic             p_valid;
    logic             p_ready;
    logic [PIX_W-1:0] p_r;
    logic [PIX_W-1:0] p_g;
    logic [PIX_W-1:0] p_b;

    modport slave (
        input  c_valid, c_r, c_g, c_b, p_ready,
        output c_ready, p_valid, p_r, p_g, p_b
    );

    modport master (
        output c_valid, c_r, c_g, c_b, p_ready,
        input  c_ready, p_valid, p_r, p_g, p_b
    );

endinterface

// File: rtl/key_fifo.sv
// Key-triplet FIFO: push visible to pop one cycle later (no bypass).
// Full/empty come from the registered count, so a push on a full FIFO is refused even with a pop.
module key_fifo
    import crypto_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rgb_t          wdata,
    input  logic          pop,
    output rgb_t          rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    rgb_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/decrypt_stream.sv
// XORs cipher pixels with queued keystream triplets; one pixel per cycle, result one cycle after accept.
// Stalls cipher input when no key is queued or the output register is held by sink backpressure.
module decrypt_stream
    import crypto_pkg::*;
#(
    parameter  int NUM_PIXELS = 65536,
    parameter  int KEY_DEPTH  = 4,
    localparam int CNT_W      = $clog2(NUM_PIXELS + 1),
    localparam int KCW        = $clog2(KEY_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 Key_ready,
    input  logic [PIX_W-1:0]     R_random,
    input  logic [PIX_W-1:0]     G_random,
    input  logic [PIX_W-1:0]     B_random,
    output logic                 key_hold,
    decrypt_stream_if.slave      bus,
    output logic [CNT_W-1:0]     pix_count,
    output logic                 done,
    output logic                 key_overflow
);

    dec_state_t       r_state;
    dec_state_t       w_state_nxt;
    rgb_t             w_key;
    rgb_t             w_cipher;
    logic             w_full;
    logic             w_empty;
    logic [KCW-1:0]   w_key_cnt;
    logic             w_c_hs;
    logic             w_p_hs;
    logic             w_last_out;
    logic             w_frame_taken;
    logic [CNT_W:0]   w_accepted;
    logic             r_p_valid;
    rgb_t             r_p_dat;
    logic [CNT_W-1:0] r_pix_count;
    logic             r_key_ovf;

    key_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (Key_ready),
        .wdata ({R_random, G_random, B_random}),
        .pop   (w_c_hs),
        .rdata (w_key),
        .full  (w_full),
        .empty (w_empty),
        .count (w_key_cnt)
    );

    // Pixels delivered plus the one parked in the output register; once this reaches
    // a full frame no more cipher is taken, so the register is empty on entering DONE.
    assign w_accepted    = {1'b0, r_pix_count} + {{CNT_W{1'b0}}, r_p_valid};
    assign w_frame_taken = (w_accepted >= (CNT_W + 1)'(NUM_PIXELS));

    assign w_cipher    = {bus.c_r, bus.c_g, bus.c_b};
    assign bus.c_ready = (r_state == RUN) & ~w_empty & (~r_p_valid | bus.p_ready) & ~w_frame_taken;
    assign w_c_hs      = bus.c_valid & bus.c_ready;
    assign w_p_hs      = r_p_valid & bus.p_ready;
    assign w_last_out  = w_p_hs & (r_pix_count == CNT_W'(NUM_PIXELS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)      w_state_nxt = RUN;
            RUN:     if (w_last_out) w_state_nxt = DONE;
            DONE:    if (start)      w_state_nxt = RUN;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_p_valid   <= 1'b0;
            r_p_dat     <= '0;
            r_pix_count <= '0;
            r_key_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_c_hs) begin
                r_p_valid <= 1'b1;
                r_p_dat   <= rgb_xor(w_cipher, w_key);
            end else if (bus.p_ready) begin
                r_p_valid <= 1'b0;
            end

            if (r_state == DONE && start) begin
                r_pix_count <= '0;
            end else if (w_p_hs && r_pix_count != CNT_W'(NUM_PIXELS)) begin
                r_pix_count <= r_pix_count + 1'b1;
            end

            if (Key_ready && w_full) begin
                r_key_ovf <= 1'b1;
            end
        end
    end

    assign key_hold     = (w_key_cnt == KCW'(KEY_DEPTH));
    assign bus.p_valid  = r_p_valid;
    assign bus.p_r      = r_p_dat.r;
    assign bus.p_g      = r_p_dat.g;
    assign bus.p_b      = r_p_dat.b;
    assign pix_count    = r_pix_count;
    assign done         = (r_state == DONE);
    assign key_overflow = r_key_ovf;

endmodule

// File: tb/tb_decrypt_stream.sv
// Directed bench for decrypt_stream with an 8-pixel frame and a 4-deep key FIFO.
module tb_decrypt_stream;
    import crypto_pkg::*;

    localparam int NP = 8;
    localparam int KD = 4;
    localparam int CW = $clog2(NP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          Key_ready;
    logic [7:0]    R_random;
    logic [7:0]    G_random;
    logic [7:0]    B_random;
    logic          key_hold;
    logic          done;
    logic          key_overflow;
    logic [CW-1:0] pix_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    rgb_t keyq[$];
    rgb_t cq[$];
    rgb_t eq[$];
    rgb_t hold_exp;

    logic [23:0] ktab [4] = '{24'h1122F0, 24'h3344E1, 24'h5566D2, 24'h7788C3};
    logic [23:0] ctab [4] = '{24'h010203, 24'h102030, 24'hA0B0C0, 24'h0F0F0F};

    decrypt_stream_if bus ();

    decrypt_stream #(.NUM_PIXELS(NP), .KEY_DEPTH(KD)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Key_ready    (Key_ready),
        .R_random     (R_random),
        .G_random     (G_random),
        .B_random     (B_random),
        .key_hold     (key_hold),
        .bus          (bus),
        .pix_count    (pix_count),
        .done         (done),
        .key_overflow (key_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_key(input logic [23:0] k, input bit keep);
        Key_ready = 1'b1;
        {R_random, G_random, B_random} = k;
        tick();
        Key_ready = 1'b0;
        if (keep) keyq.push_back(rgb_t'(k));
    endtask

    task automatic add_pix(input logic [23:0] c);
        rgb_t k;
        k = keyq.pop_front();
        cq.push_back(rgb_t'(c));
        eq.push_back(rgb_xor(rgb_t'(c), k));
    endtask

    // Offers queued cipher pixels and checks every plaintext handshake against the model.
    task automatic stream(input int n_send, input int n_get, input int budget, output int cycles);
        int sent;
        int got;
        sent   = 0;
        got    = 0;
        cycles = 0;
        while ((sent < n_send || got < n_get) && cycles < budget) begin
            if (sent < n_send) begin
                bus.c_valid = 1'b1;
                {bus.c_r, bus.c_g, bus.c_b} = cq[0];
            end else begin
                bus.c_valid = 1'b0;
            end
            #1;
            if (bus.p_valid && bus.p_ready) begin
                if (eq.size() == 0) begin
                    check("extra_pixel", 32'd1, 32'd0);
                end else begin
                    check("pixel", {8'h0, bus.p_r, bus.p_g, bus.p_b}, {8'h0, eq[0]});
                    eq.delete(0);
                end
                got++;
            end
            if (bus.c_valid && bus.c_ready) begin
                cq.delete(0);
                sent++;
            end
            tick();
            cycles++;
        end
        bus.c_valid = 1'b0;
        check("stream_count", sent + got, n_send + n_get);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; Key_ready = 1'b0;
        R_random = '0; G_random = '0; B_random = '0;
        bus.c_valid = 1'b0; bus.c_r = '0; bus.c_g = '0; bus.c_b = '0; bus.p_ready = 1'b0;
        tick(); tick();
        check("rst_p_valid", bus.p_valid, 0);
        check("rst_c_ready", bus.c_ready, 0);
        check("rst_key_hold", key_hold, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_done", done, 0);
        check("rst_overflow", key_overflow, 0);
        check("rst_p_data", {bus.p_r, bus.p_g, bus.p_b}, 0);

        rst = 1'b0; start = 1'b1; tick(); start = 1'b0;

        // Key starvation, then the basic XOR vector.
        bus.c_valid = 1'b1; {bus.c_r, bus.c_g, bus.c_b} = 24'h123456; #1;
        check("starve_c_ready", bus.c_ready, 0);
        tick();
        Key_ready = 1'b1; {R_random, G_random, B_random} = 24'h5AA53C; #1;
        check("no_bypass", bus.c_ready, 0);
        tick(); Key_ready = 1'b0; #1;
        check("key_then_ready", bus.c_ready, 1);
        tick(); bus.c_valid = 1'b0; #1;
        check("xor_valid", bus.p_valid, 1);
        check("xor_data", {bus.p_r, bus.p_g, bus.p_b}, 24'h48916A);
        check("xor_fifo_empty", bus.c_ready, 0);
        bus.p_ready = 1'b1; tick(); #1;
        check("drain_valid", bus.p_valid, 0);
        check("count_1", pix_count, 1);
        tick();

        // Fill the FIFO, overflow it, then confirm the first four keys are used.
        for (int i = 0; i < 4; i++) push_key(ktab[i], 1'b1);
        #1;
        check("full_key_hold", key_hold, 1);
        check("full_no_overflow", key_overflow, 0);
        tick();
        push_key(24'hFFFFFF, 1'b0);
        #1;
        check("overflow_set", key_overflow, 1);
        check("overflow_key_hold", key_hold, 1);
        tick();
        for (int i = 0; i < 4; i++) add_pix(ctab[i]);
        stream(4, 4, 20, cyc);
        check("throughput_cycles", cyc, 5);
        check("count_5", pix_count, 5);
        check("drained_key_hold", key_hold, 0);

        // Sink backpressure for five cycles.
        push_key(24'h13579B, 1'b1);
        push_key(24'h2468AC, 1'b1);
        add_pix(24'hDEADBE);
        add_pix(24'hCAFE00);
        bus.p_ready = 1'b0;
        bus.c_valid = 1'b1; {bus.c_r, bus.c_g, bus.c_b} = cq[0]; #1;
        check("bp_accept", bus.c_ready, 1);
        tick();
        cq.delete(0);
        {bus.c_r, bus.c_g, bus.c_b} = cq[0];
        hold_exp = eq[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", bus.p_valid, 1);
            check("bp_hold_data", {bus.p_r, bus.p_g, bus.p_b}, hold_exp);
            check("bp_c_ready", bus.c_ready, 0);
            tick();
        end
        bus.p_ready = 1'b1;
        stream(1, 2, 10, cyc);
        check("count_7", pix_count, 7);

        // Last pixel of the frame.
        push_key(24'h0F1E2D, 1'b1);
        add_pix(24'h445566);
        stream(1, 1, 10, cyc);
        #1;
        check("frame_done", done, 1);
        check("frame_count", pix_count, 8);
        tick();
        push_key(24'h9A8B7C, 1'b1);
        bus.c_valid = 1'b1; {bus.c_r, bus.c_g, bus.c_b} = 24'h111111; #1;
        check("done_c_ready", bus.c_ready, 0);
        tick();
        bus.c_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0; #1;
        check("restart_done", done, 0);
        check("restart_count", pix_count, 0);
        tick();
        add_pix(24'hABCDEF);
        stream(1, 1, 10, cyc);
        check("next_frame_count", pix_count, 1);

        // Reset mid-frame with keys queued.
        push_key(24'h31415F, 1'b1);
        push_key(24'h27182B, 1'b1);
        add_pix(24'h0A0B0C);
        add_pix(24'hF0E0D0);
        stream(2, 2, 10, cyc);
        check("pre_rst_count", pix_count, 3);
        push_key(24'h777777, 1'b0);
        push_key(24'h888888, 1'b0);
        #1;
        check("sticky_overflow", key_overflow, 1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("mid_rst_p_valid", bus.p_valid, 0);
        check("mid_rst_p_data", {bus.p_r, bus.p_g, bus.p_b}, 0);
        check("mid_rst_count", pix_count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overflow", key_overflow, 0);
        check("mid_rst_key_hold", key_hold, 0);
        tick();
        start = 1'b1; bus.c_valid = 1'b1; tick(); start = 1'b0; #1;
        check("mid_rst_fifo_empty", bus.c_ready, 0);
        bus.c_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
